// File: rtl/fastcounter_seq_ctl_if.sv
// Control and status pins between the sequencer and one fastcounter instance.
// Signal names are from the sequencer's point of view.
interface fastcounter_seq_ctl_if #(
  parameter int unsigned NBITS = 9
);
  logic             o_cnt_mode;
  logic             o_cnt_en;
  logic             o_cnt_load;
  logic [NBITS-1:0] o_cnt_load_q;
  logic             i_cnt_zpulse;

  modport master (
    output o_cnt_mode, o_cnt_en, o_cnt_load, o_cnt_load_q,
    input  i_cnt_zpulse
  );

  modport slave (
    input  o_cnt_mode, o_cnt_en, o_cnt_load, o_cnt_load_q,
    output i_cnt_zpulse
  );
endinterface

// File: rtl/fastcounter_seq_ctl.sv
// Oneshot interval sequencer: walks a table of intervals through a fastcounter,
// strobing step per expired slot and done at the end of a non-looping run.
module fastcounter_seq_ctl #(
  parameter  int unsigned NBITS  = 9,
  parameter  int unsigned NSLOTS = 4,
  localparam int unsigned SLOT_W = $clog2(NSLOTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cfg_we,
  input  logic [SLOT_W-1:0]     i_cfg_addr,
  input  logic [NBITS-1:0]      i_cfg_data,
  input  logic [SLOT_W-1:0]     i_cfg_len,
  input  logic                  i_cfg_loop,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_tick,
  fastcounter_seq_ctl_if.master cnt,
  output logic                  o_busy,
  output logic [SLOT_W-1:0]     o_slot,
  output logic                  o_step,
  output logic                  o_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_STEP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] len_q, len_d;
  logic              loop_q, loop_d;
  logic [NBITS-1:0]  tbl_q [NSLOTS];
  logic [NBITS-1:0]  tbl_d [NSLOTS];
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic              load_q, load_d;
  logic [NBITS-1:0]  load_val_q, load_val_d;
  logic              step_q, step_d;
  logic              done_q, done_d;

  logic              addr_ok_c;
  logic [SLOT_W-1:0] len_sat_c;

  // Range guards only exist when the index field can address past the table.
  generate
    if ((2 ** SLOT_W) == NSLOTS) begin : g_full_range
      assign addr_ok_c = 1'b1;
      assign len_sat_c = i_cfg_len;
    end else begin : g_part_range
      localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NSLOTS - 1);
      assign addr_ok_c = (i_cfg_addr <= LAST);
      assign len_sat_c = (i_cfg_len > LAST) ? LAST : i_cfg_len;
    end
  endgenerate

  // Interval table write port, usable in any state.
  always_comb begin
    tbl_d = tbl_q;
    if (i_cfg_we && addr_ok_c) begin
      tbl_d[i_cfg_addr] = i_cfg_data;
    end
  end

  // Next state, then outputs as they must appear in that next state.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    len_d   = len_q;
    loop_d  = loop_q;

    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_LOAD;
            slot_d  = '0;
            len_d   = len_sat_c;
            loop_d  = i_cfg_loop;
          end
        end
        // A zero interval never loads the counter and expires at once.
        ST_LOAD: state_d = load_q ? ST_WAIT : ST_STEP;
        ST_WAIT: begin
          if (cnt.i_cnt_zpulse) begin
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          if (slot_q == len_q) begin
            if (loop_q) begin
              slot_d  = '0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = ST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d     = (state_d != ST_IDLE);
    load_d     = (state_d == ST_LOAD) && (tbl_q[slot_d] != '0);
    load_val_d = load_d ? tbl_q[slot_d] : '0;
    en_d       = (state_d == ST_WAIT) && i_tick;
    step_d     = (state_d == ST_STEP);
    done_d     = step_d && (slot_d == len_d) && !loop_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      load_q     <= 1'b0;
      load_val_q <= '0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      step_q     <= step_d;
      done_q     <= done_d;
      tbl_q      <= tbl_d;
    end
  end

  assign cnt.o_cnt_mode   = 1'b1;
  assign cnt.o_cnt_en     = en_q;
  assign cnt.o_cnt_load   = load_q;
  assign cnt.o_cnt_load_q = load_val_q;
  assign o_busy           = busy_q;
  assign o_slot           = slot_q;
  assign o_step           = step_q;
  assign o_done           = done_q;

endmodule

// File: tb/tb_fastcounter_seq_ctl.sv
// Bench for fastcounter_seq_ctl: cycle model of the sequencing rules plus a
// simple oneshot counter model, with directed scenarios and literal expectations.
module tb_fastcounter_seq_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [8:0] cfg_data = 9'd0;
  logic [1:0] cfg_len = 2'd0;
  logic       cfg_loop = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tick = 1'b0;
  logic       zp_model = 1'b0;
  logic       zp_force = 1'b0;
  logic       busy, step, done;
  logic [1:0] slot;

  fastcounter_seq_ctl_if #(.NBITS(9)) bus ();
  assign bus.i_cnt_zpulse = zp_model | zp_force;

  fastcounter_seq_ctl #(.NBITS(9), .NSLOTS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .i_cfg_len(cfg_len), .i_cfg_loop(cfg_loop),
    .i_start(start), .i_abort(abort), .i_tick(tick),
    .cnt(bus),
    .o_busy(busy), .o_slot(slot), .o_step(step), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 load, 2 wait, 3 step.
  int m_tbl[4] = '{0, 0, 0, 0};
  int m_phase = 0, m_slot = 0, m_len = 0, m_loadq = 0;
  bit m_loop = 0, m_busy = 0, m_en = 0, m_load = 0, m_step = 0, m_done = 0;
  bit prev_load;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_slot = 0; m_len = 0; m_loadq = 0; m_loop = 0;
      m_busy = 0; m_en = 0; m_load = 0; m_step = 0; m_done = 0;
      foreach (m_tbl[i]) m_tbl[i] = 0;
    end else begin
      prev_load = m_load;
      m_en = 0; m_load = 0; m_step = 0; m_done = 0;
      if (abort) m_phase = 0;
      else begin
        case (m_phase)
          0: if (start) begin
               m_slot = 0; m_loop = cfg_loop; m_phase = 1;
               m_len = int'(cfg_len);
               if (m_len > 3) m_len = 3;
             end
          1: m_phase = prev_load ? 2 : 3;
          2: if (bus.i_cnt_zpulse) m_phase = 3;
          default: begin
            if (m_slot == m_len) begin
              if (m_loop) begin m_slot = 0; m_phase = 1; end
              else m_phase = 0;
            end else begin
              m_slot = m_slot + 1; m_phase = 1;
            end
          end
        endcase
      end
      if (m_phase == 1) begin
        m_load  = (m_tbl[m_slot] != 0);
        m_loadq = m_tbl[m_slot];
      end
      m_busy = (m_phase != 0);
      if (m_phase == 2) m_en = tick;
      if (m_phase == 3) begin
        m_step = 1;
        m_done = (m_slot == m_len) && !m_loop;
      end
      if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
    end
  end

  // Per-cycle compare, event logging and oneshot counter model.
  int q_load[$];
  int q_step[$];
  int done_cnt = 0, done_slot = 0, done_cyc = 0, busy_fall_cyc = 0, cyc = 0, rem = 0;
  bit prev_busy = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      zp_model = 1'b0; rem = 0; prev_busy = 0;
    end else begin
      chk("busy", busy, m_busy);
      chk("cnt_en", bus.o_cnt_en, m_en);
      chk("cnt_load", bus.o_cnt_load, m_load);
      chk("step", step, m_step);
      chk("done", done, m_done);
      chk("cnt_mode", bus.o_cnt_mode, 1);
      if (m_step) chk("slot", slot, m_slot);
      if (m_load) chk("load_q", bus.o_cnt_load_q, m_loadq);
      if (bus.o_cnt_load) q_load.push_back(int'(bus.o_cnt_load_q));
      if (step) q_step.push_back(int'(slot));
      if (done) begin done_cnt++; done_slot = int'(slot); done_cyc = cyc; end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      zp_model = 1'b0;
      if (bus.o_cnt_load) rem = int'(bus.o_cnt_load_q);
      else if (bus.o_cnt_en && rem > 0) begin
        rem--;
        if (rem == 0) zp_model = 1'b1;
      end
    end
  end

  function automatic int cur(input int which);
    case (which)
      0: return q_step.size();
      1: return done_cnt;
      default: return q_load.size();
    endcase
  endfunction

  // which: 0 steps, 1 dones, 2 loads
  task automatic wait_cnt(input int which, input int target, input int budget, input bit toggle);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (cur(which) >= target) return;
      @(negedge clk);
      if (toggle) tick = ~tick;
    end
    checks++; errors++;
    $display("FAIL wait_timeout which=%0d actual=%0d expected=%0d", which, cur(which), target);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 9'(d);
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int lb, sb, db, lb2, sb2;
  int e1[4] = '{3, 5, 2, 4};
  int e5[4] = '{3, 5, 9, 4};

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mode", bus.o_cnt_mode, 1);
    chk("rst_en", bus.o_cnt_en, 0);
    chk("rst_load_q", bus.o_cnt_load_q, 0);
    chk("rst_slot", slot, 0);

    // Basic non-looping run
    wr(0, 3); wr(1, 5); wr(2, 2); wr(3, 4);
    cfg_len = 2'd3; cfg_loop = 1'b0; tick = 1'b1;
    lb = q_load.size(); sb = q_step.size(); db = done_cnt;
    pulse_start();
    wait_cnt(1, db + 1, 200, 0);
    idle(2);
    chk("s1_nload", q_load.size() - lb, 4);
    chk("s1_nstep", q_step.size() - sb, 4);
    for (int i = 0; i < 4; i++) begin
      if (q_load.size() > lb + i) chk("s1_load_val", q_load[lb + i], e1[i]);
      if (q_step.size() > sb + i) chk("s1_step_slot", q_step[sb + i], i);
    end
    chk("s1_done", done_cnt - db, 1);
    chk("s1_done_slot", done_slot, 3);
    chk("s1_busy_fall", busy_fall_cyc - done_cyc, 1);

    // Looping run, aborted while waiting on slot 1
    cfg_loop = 1'b1;
    sb = q_step.size(); db = done_cnt;
    pulse_start();
    wait_cnt(0, sb + 9, 400, 0);
    idle(2);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("s2_busy_after_abort", busy, 0);
    lb2 = q_load.size(); sb2 = q_step.size();
    idle(20);
    chk("s2_no_load", q_load.size(), lb2);
    chk("s2_no_step", q_step.size(), sb2);
    chk("s2_nstep", q_step.size() - sb, 9);
    for (int i = 0; i < 9; i++)
      if (q_step.size() > sb + i) chk("s2_step_slot", q_step[sb + i], i % 4);
    chk("s2_no_done", done_cnt - db, 0);
    cfg_loop = 1'b0;

    // Zero intervals expire without a counter load
    wr(0, 0); wr(1, 7); wr(2, 0); wr(3, 0);
    cfg_len = 2'd1;
    lb = q_load.size(); sb = q_step.size(); db = done_cnt;
    pulse_start();
    wait_cnt(1, db + 1, 200, 0);
    idle(2);
    chk("s3_nload", q_load.size() - lb, 1);
    if (q_load.size() > lb) chk("s3_load_val", q_load[lb], 7);
    chk("s3_nstep", q_step.size() - sb, 2);
    if (q_step.size() > sb + 1) begin
      chk("s3_step0", q_step[sb], 0);
      chk("s3_step1", q_step[sb + 1], 1);
    end
    chk("s3_done", done_cnt - db, 1);

    // Toggling tick, spurious zero pulses in IDLE and LOAD
    wr(0, 3);
    cfg_len = 2'd0;
    lb = q_load.size(); sb = q_step.size(); db = done_cnt;
    @(negedge clk); zp_force = 1'b1;
    @(negedge clk); zp_force = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; zp_force = 1'b1;
    @(negedge clk); zp_force = 1'b0;
    wait_cnt(1, db + 1, 200, 1);
    tick = 1'b1;
    idle(2);
    chk("s4_nstep", q_step.size() - sb, 1);
    chk("s4_nload", q_load.size() - lb, 1);
    if (q_load.size() > lb) chk("s4_load_val", q_load[lb], 3);
    chk("s4_done", done_cnt - db, 1);

    // Start and abort together stay idle
    lb = q_load.size();
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    idle(3);
    chk("s5_sa_busy", busy, 0);
    chk("s5_sa_noload", q_load.size(), lb);

    // Table rewrite mid-run and ignored restart
    wr(0, 3); wr(1, 5); wr(2, 2); wr(3, 4);
    cfg_len = 2'd3;
    lb = q_load.size(); sb = q_step.size(); db = done_cnt;
    pulse_start();
    wait_cnt(0, sb + 1, 200, 0);
    idle(2);
    wr(2, 9);
    pulse_start();
    wait_cnt(1, db + 1, 200, 0);
    idle(2);
    chk("s5_nload", q_load.size() - lb, 4);
    for (int i = 0; i < 4; i++)
      if (q_load.size() > lb + i) chk("s5_load_val", q_load[lb + i], e5[i]);
    chk("s5_nstep", q_step.size() - sb, 4);
    chk("s5_done", done_cnt - db, 1);

    // Async reset while waiting clears outputs and table
    lb = q_load.size();
    pulse_start();
    wait_cnt(2, lb + 1, 200, 0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_en", bus.o_cnt_en, 0);
    chk("s6_load", bus.o_cnt_load, 0);
    chk("s6_load_q", bus.o_cnt_load_q, 0);
    chk("s6_step", step, 0);
    chk("s6_done", done, 0);
    chk("s6_slot", slot, 0);
    chk("s6_mode", bus.o_cnt_mode, 1);
    @(negedge clk); rst_n = 1'b1;
    cfg_len = 2'd3;
    lb = q_load.size(); sb = q_step.size(); db = done_cnt;
    pulse_start();
    wait_cnt(1, db + 1, 200, 0);
    idle(2);
    chk("s6_cleared_noload", q_load.size() - lb, 0);
    chk("s6_nstep", q_step.size() - sb, 4);
    for (int i = 0; i < 4; i++)
      if (q_step.size() > sb + i) chk("s6_step_slot", q_step[sb + i], i);
    chk("s6_done_cnt", done_cnt - db, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
